// File: rtl/correl_pkg.sv
// Shared types and constants for the correlator frame sequencer.
package correl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CFG_FFT  = 3'd1,
    ST_CFG_IFFT = 3'd2,
    ST_STREAM   = 3'd3,
    ST_DRAIN    = 3'd4
  } state_t;

  // Forward transform, no scaling override.
  localparam logic [15:0] FFT_CFG_FWD      = 16'h0001;
  // Inverse transform, scale schedule 01010.
  localparam logic [23:0] IFFT_CFG_DEFAULT = 24'h00000A;

  // Complex sample layout: {im, re}.
  localparam int CPLX_W = 32;
  localparam int PART_W = 16;
  localparam int RE_LSB = 0;
  localparam int IM_LSB = 16;

endpackage

// File: rtl/correl_frame_ctrl_axis_join2.sv
// Two-stream valid/ready join: both inputs advance together or not at all.
module axis_join2 (
  input  logic en,
  input  logic s_a_tvalid,
  input  logic s_b_tvalid,
  input  logic m_a_tready,
  input  logic m_b_tready,
  output logic m_tvalid,
  output logic s_tready
);

  // Output is offered only when both sources have data, and a source is
  // consumed only when both sinks take it, so the pair can never skew.
  assign m_tvalid = en & s_a_tvalid & s_b_tvalid;
  assign s_tready = m_tvalid & m_a_tready & m_b_tready;

endmodule

// File: rtl/correl_frame_ctrl.sv
// Frame sequencer for the FFT -> x conj(SF) -> IFFT correlator.
//
// state       | meaning
// ------------+----------------------------------------------------------
// ST_IDLE     | waiting for start; all streams blocked
// ST_CFG_FFT  | offering the FFT config word until accepted
// ST_CFG_IFFT | offering the IFFT config word until accepted
// ST_STREAM   | passing N joined sig/SF beats, tlast on the last one
// ST_DRAIN    | streams blocked until the IFFT result frame ends
module correl_frame_ctrl
  import correl_pkg::*;
#(
  parameter int          N_LOG2   = 10,
  parameter logic [15:0] FFT_CFG  = FFT_CFG_FWD,
  parameter logic [23:0] IFFT_CFG = IFFT_CFG_DEFAULT
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              start,
  input  logic [15:0]       num_frames,
  input  logic              stop,
  output logic [15:0]       fft_cfg_tdata,
  output logic              fft_cfg_tvalid,
  input  logic              fft_cfg_tready,
  output logic [23:0]       ifft_cfg_tdata,
  output logic              ifft_cfg_tvalid,
  input  logic              ifft_cfg_tready,
  input  logic [CPLX_W-1:0] s_sig_tdata,
  input  logic              s_sig_tvalid,
  output logic              s_sig_tready,
  input  logic [CPLX_W-1:0] s_sf_tdata,
  input  logic              s_sf_tvalid,
  output logic              s_sf_tready,
  output logic [CPLX_W-1:0] m_sig_tdata,
  output logic              m_sig_tvalid,
  output logic              m_sig_tlast,
  input  logic              m_sig_tready,
  output logic [CPLX_W-1:0] m_sf_tdata,
  output logic              m_sf_tvalid,
  input  logic              m_sf_tready,
  input  logic              res_tvalid,
  input  logic              res_tready,
  input  logic              res_tlast,
  output logic              busy,
  output logic [15:0]       frame_cnt,
  output logic              err_len
);

  localparam logic [N_LOG2-1:0] SMP_LAST = {N_LOG2{1'b1}};
  localparam logic [N_LOG2-1:0] SMP_ONE  = 1;

  state_t            state;
  logic [N_LOG2-1:0] smp_cnt;
  logic [N_LOG2-1:0] res_cnt;
  logic [15:0]       num_frames_q;
  logic [15:0]       frame_cnt_nxt;
  logic              stop_pending;
  logic              join_en;
  logic              join_valid;
  logic              join_beat;
  logic              res_beat;
  logic              res_last_beat;
  logic              start_acc;
  logic              run_done;

  assign join_en = (state == ST_STREAM);

  axis_join2 u_join (
    .en         (join_en),
    .s_a_tvalid (s_sig_tvalid),
    .s_b_tvalid (s_sf_tvalid),
    .m_a_tready (m_sig_tready),
    .m_b_tready (m_sf_tready),
    .m_tvalid   (join_valid),
    .s_tready   (join_beat)
  );

  assign m_sig_tvalid   = join_valid;
  assign m_sf_tvalid    = join_valid;
  assign s_sig_tready   = join_beat;
  assign s_sf_tready    = join_beat;
  assign m_sig_tdata    = s_sig_tdata;
  assign m_sf_tdata     = s_sf_tdata;
  assign m_sig_tlast    = join_valid & (smp_cnt == SMP_LAST);

  assign fft_cfg_tdata  = FFT_CFG;
  assign ifft_cfg_tdata = IFFT_CFG;
  assign busy           = (state != ST_IDLE);

  assign res_beat       = res_tvalid & res_tready;
  assign res_last_beat  = res_beat & res_tlast;
  assign start_acc      = (state == ST_IDLE) & start;
  assign frame_cnt_nxt  = frame_cnt + 16'd1;
  // A stop arriving in the same cycle as the closing result beat still ends the run.
  assign run_done       = stop_pending | stop |
                          ((num_frames_q != 16'd0) && (frame_cnt_nxt == num_frames_q));

  // Sequencer: config handshakes, frame streaming and result draining.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state           <= ST_IDLE;
      fft_cfg_tvalid  <= 1'b0;
      ifft_cfg_tvalid <= 1'b0;
      smp_cnt         <= '0;
      num_frames_q    <= '0;
      frame_cnt       <= '0;
      stop_pending    <= 1'b0;
    end else begin
      // Set first so the end-of-run clear below takes precedence.
      if (busy && stop) stop_pending <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (start) begin
            state          <= ST_CFG_FFT;
            fft_cfg_tvalid <= 1'b1;
            num_frames_q   <= num_frames;
            frame_cnt      <= '0;
            stop_pending   <= 1'b0;
          end
        end
        ST_CFG_FFT: begin
          if (fft_cfg_tready) begin
            fft_cfg_tvalid  <= 1'b0;
            ifft_cfg_tvalid <= 1'b1;
            state           <= ST_CFG_IFFT;
          end
        end
        ST_CFG_IFFT: begin
          if (ifft_cfg_tready) begin
            ifft_cfg_tvalid <= 1'b0;
            smp_cnt         <= '0;
            state           <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (join_beat) begin
            if (smp_cnt == SMP_LAST) begin
              smp_cnt <= '0;
              state   <= ST_DRAIN;
            end else begin
              smp_cnt <= smp_cnt + SMP_ONE;
            end
          end
        end
        ST_DRAIN: begin
          if (res_last_beat) begin
            frame_cnt <= frame_cnt_nxt;
            if (run_done) begin
              state        <= ST_IDLE;
              stop_pending <= 1'b0;
            end else begin
              state <= ST_STREAM;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Result-frame length monitor; a tlast while frames are still going out is also an error.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      res_cnt <= '0;
      err_len <= 1'b0;
    end else begin
      if (res_beat) res_cnt <= res_tlast ? '0 : (res_cnt + SMP_ONE);

      if (start_acc) begin
        err_len <= 1'b0;
      end else if (res_last_beat &&
                   ((res_cnt != SMP_LAST) ||
                    (state inside {ST_CFG_FFT, ST_CFG_IFFT, ST_STREAM}))) begin
        err_len <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_correl_frame_ctrl.sv
// Directed bench for correl_frame_ctrl with a beat monitor on the joined streams.
module tb_correl_frame_ctrl;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_frames = 16'd0;
  logic        stop = 1'b0;
  logic [15:0] fft_cfg_tdata;
  logic        fft_cfg_tvalid;
  logic        fft_cfg_tready = 1'b0;
  logic [23:0] ifft_cfg_tdata;
  logic        ifft_cfg_tvalid;
  logic        ifft_cfg_tready = 1'b0;
  logic [31:0] s_sig_tdata;
  logic        s_sig_tvalid = 1'b1;
  logic        s_sig_tready;
  logic [31:0] s_sf_tdata;
  logic        s_sf_tvalid = 1'b1;
  logic        s_sf_tready;
  logic [31:0] m_sig_tdata;
  logic        m_sig_tvalid;
  logic        m_sig_tlast;
  logic        m_sig_tready = 1'b1;
  logic [31:0] m_sf_tdata;
  logic        m_sf_tvalid;
  logic        m_sf_tready = 1'b1;
  logic        res_tvalid = 1'b0;
  logic        res_tready = 1'b0;
  logic        res_tlast = 1'b0;
  logic        busy;
  logic [15:0] frame_cnt;
  logic        err_len;

  int n_assert = 0;
  int n_fail   = 0;

  // monitor state
  logic [15:0] sig_idx = 16'd0;
  logic [15:0] sf_idx  = 16'd0;
  int beats = 0, viol = 0, skew = 0, ord_err = 0, tlast_cnt = 0, tlast_err = 0, pos = 0;

  always #5 aclk = ~aclk;

  assign s_sig_tdata = {16'h51A0, sig_idx};
  assign s_sf_tdata  = {16'h5F00, sf_idx};

  correl_frame_ctrl dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .start           (start),
    .num_frames      (num_frames),
    .stop            (stop),
    .fft_cfg_tdata   (fft_cfg_tdata),
    .fft_cfg_tvalid  (fft_cfg_tvalid),
    .fft_cfg_tready  (fft_cfg_tready),
    .ifft_cfg_tdata  (ifft_cfg_tdata),
    .ifft_cfg_tvalid (ifft_cfg_tvalid),
    .ifft_cfg_tready (ifft_cfg_tready),
    .s_sig_tdata     (s_sig_tdata),
    .s_sig_tvalid    (s_sig_tvalid),
    .s_sig_tready    (s_sig_tready),
    .s_sf_tdata      (s_sf_tdata),
    .s_sf_tvalid     (s_sf_tvalid),
    .s_sf_tready     (s_sf_tready),
    .m_sig_tdata     (m_sig_tdata),
    .m_sig_tvalid    (m_sig_tvalid),
    .m_sig_tlast     (m_sig_tlast),
    .m_sig_tready    (m_sig_tready),
    .m_sf_tdata      (m_sf_tdata),
    .m_sf_tvalid     (m_sf_tvalid),
    .m_sf_tready     (m_sf_tready),
    .res_tvalid      (res_tvalid),
    .res_tready      (res_tready),
    .res_tlast       (res_tlast),
    .busy            (busy),
    .frame_cnt       (frame_cnt),
    .err_len         (err_len)
  );

  logic all4, out_beat, hs_bad;
  assign all4     = s_sig_tvalid & s_sf_tvalid & m_sig_tready & m_sf_tready;
  assign out_beat = m_sig_tvalid & m_sig_tready & m_sf_tvalid & m_sf_tready;
  assign hs_bad   = (s_sig_tready !== s_sf_tready) ||
                    (m_sig_tvalid !== m_sf_tvalid) ||
                    (s_sig_tready && !all4) ||
                    (m_sig_tvalid && !(s_sig_tvalid && s_sf_tvalid)) ||
                    (out_beat !== s_sig_tready);

  // Beat monitor: source consumption, pairing, ordering and tlast position.
  always @(posedge aclk) begin
    if (s_sig_tvalid && s_sig_tready) sig_idx <= sig_idx + 16'd1;
    if (s_sf_tvalid && s_sf_tready)   sf_idx  <= sf_idx + 16'd1;
    if (hs_bad) viol <= viol + 1;
    if (!aresetn) begin
      pos <= 0;
    end else if (out_beat) begin
      beats <= beats + 1;
      if (m_sig_tdata[15:0] !== m_sf_tdata[15:0]) skew <= skew + 1;
      if (m_sig_tdata !== {16'h51A0, sig_idx} || m_sf_tdata !== {16'h5F00, sf_idx})
        ord_err <= ord_err + 1;
      if (m_sig_tlast) tlast_cnt <= tlast_cnt + 1;
      if (m_sig_tlast !== (pos == 1023)) tlast_err <= tlast_err + 1;
      pos <= (pos == 1023) ? 0 : pos + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] nf);
    num_frames = nf;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_beats(input int target, input int budget, input bit rnd, input string tag);
    int n = 0;
    while (beats < target && n < budget) begin
      if (rnd) begin
        s_sig_tvalid = ($urandom_range(0, 3) != 0);
        s_sf_tvalid  = ($urandom_range(0, 3) != 0);
        m_sig_tready = ($urandom_range(0, 3) != 0);
        m_sf_tready  = ($urandom_range(0, 3) != 0);
      end
      step();
      n++;
    end
    s_sig_tvalid = 1'b1;
    s_sf_tvalid  = 1'b1;
    m_sig_tready = 1'b1;
    m_sf_tready  = 1'b1;
    check_val(tag, beats, target);
  endtask

  task automatic hold_check(input int cycles, input string tag);
    int b0 = beats;
    repeat (cycles) step();
    check_val(tag, beats, b0);
  endtask

  task automatic send_result(input int len);
    for (int i = 0; i < len; i++) begin
      res_tvalid = 1'b1;
      res_tready = 1'b1;
      res_tlast  = (i == len - 1);
      step();
    end
    res_tvalid = 1'b0;
    res_tready = 1'b0;
    res_tlast  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int base, tl;

    // reset state
    repeat (3) @(posedge aclk);
    #1;
    check_val("rst_busy",      32'(busy), 32'd0);
    check_val("rst_fft_vld",   32'(fft_cfg_tvalid), 32'd0);
    check_val("rst_ifft_vld",  32'(ifft_cfg_tvalid), 32'd0);
    check_val("rst_m_vld",     32'(m_sig_tvalid), 32'd0);
    check_val("rst_s_rdy",     32'(s_sig_tready), 32'd0);
    check_val("rst_tlast",     32'(m_sig_tlast), 32'd0);
    check_val("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check_val("rst_err_len",   32'(err_len), 32'd0);
    check_val("fft_cfg_data",  32'(fft_cfg_tdata), 32'h0001);
    check_val("ifft_cfg_data", 32'(ifft_cfg_tdata), 32'h00000A);
    aresetn = 1'b1;
    step();
    check_val("idle_m_vld", 32'(m_sig_tvalid), 32'd0);

    // 1: single frame with explicit config handshakes
    do_start(16'd1);
    check_val("t1_fft_vld",  32'(fft_cfg_tvalid), 32'd1);
    check_val("t1_busy",     32'(busy), 32'd1);
    check_val("t1_ifft_pre", 32'(ifft_cfg_tvalid), 32'd0);
    repeat (3) step();
    check_val("t1_fft_hold", 32'(fft_cfg_tvalid), 32'd1);
    fft_cfg_tready = 1'b1;
    step();
    fft_cfg_tready = 1'b0;
    check_val("t1_fft_done", 32'(fft_cfg_tvalid), 32'd0);
    check_val("t1_ifft_vld", 32'(ifft_cfg_tvalid), 32'd1);
    check_val("t1_no_strm",  32'(m_sig_tvalid), 32'd0);
    repeat (2) step();
    check_val("t1_ifft_hold", 32'(ifft_cfg_tvalid), 32'd1);
    ifft_cfg_tready = 1'b1;
    step();
    ifft_cfg_tready = 1'b0;
    check_val("t1_ifft_done", 32'(ifft_cfg_tvalid), 32'd0);
    check_val("t1_strm_vld",  32'(m_sig_tvalid), 32'd1);
    base = beats;
    tl = tlast_cnt;
    wait_beats(base + 1024, 3000, 1'b0, "t1_beats");
    check_val("t1_tlast_cnt", tlast_cnt - tl, 32'd1);
    check_val("t1_tlast_pos", tlast_err, 32'd0);
    hold_check(10, "t1_drain_hold");
    check_val("t1_drain_busy", 32'(busy), 32'd1);
    send_result(1024);
    check_val("t1_frame_cnt", 32'(frame_cnt), 32'd1);
    check_val("t1_idle",      32'(busy), 32'd0);
    check_val("t1_err_len",   32'(err_len), 32'd0);

    fft_cfg_tready  = 1'b1;
    ifft_cfg_tready = 1'b1;

    // 2: randomised handshakes
    do_start(16'd1);
    base = beats;
    tl = tlast_cnt;
    wait_beats(base + 1024, 20000, 1'b1, "t2_beats");
    check_val("t2_viol",      viol, 32'd0);
    check_val("t2_skew",      skew, 32'd0);
    check_val("t2_order",     ord_err, 32'd0);
    check_val("t2_idx_pair",  32'(sig_idx - sf_idx), 32'd0);
    check_val("t2_tlast_cnt", tlast_cnt - tl, 32'd1);
    check_val("t2_tlast_pos", tlast_err, 32'd0);
    hold_check(5, "t2_drain_hold");
    send_result(1024);
    check_val("t2_frame_cnt", 32'(frame_cnt), 32'd1);

    // 3: three frames, each held until its result drains
    do_start(16'd3);
    base = beats;
    for (int f = 0; f < 3; f++) begin
      wait_beats(base + 1024 * (f + 1), 3000, 1'b0, "t3_beats");
      hold_check(12, "t3_drain_hold");
      send_result(1024);
      check_val("t3_frame_cnt", 32'(frame_cnt), 32'(f + 1));
      check_val("t3_busy",      32'(busy), (f < 2) ? 32'd1 : 32'd0);
    end
    hold_check(10, "t3_idle_hold");

    // 4: continuous run stopped mid frame 2
    do_start(16'd0);
    base = beats;
    wait_beats(base + 1024, 3000, 1'b0, "t4_f1_beats");
    send_result(1024);
    check_val("t4_f1_cnt",  32'(frame_cnt), 32'd1);
    check_val("t4_f1_busy", 32'(busy), 32'd1);
    wait_beats(base + 1024 + 500, 3000, 1'b0, "t4_stop_pt");
    stop = 1'b1;
    step();
    stop = 1'b0;
    wait_beats(base + 2048, 3000, 1'b0, "t4_f2_beats");
    hold_check(10, "t4_drain_hold");
    check_val("t4_drain_busy", 32'(busy), 32'd1);
    send_result(1024);
    check_val("t4_frame_cnt", 32'(frame_cnt), 32'd2);
    check_val("t4_idle",      32'(busy), 32'd0);
    hold_check(10, "t4_idle_hold");

    // 5: short result frame sets sticky err_len
    do_start(16'd1);
    base = beats;
    wait_beats(base + 1024, 3000, 1'b0, "t5_beats");
    send_result(1000);
    check_val("t5_err_set",   32'(err_len), 32'd1);
    check_val("t5_frame_cnt", 32'(frame_cnt), 32'd1);
    check_val("t5_idle",      32'(busy), 32'd0);
    repeat (5) step();
    check_val("t5_err_stick", 32'(err_len), 32'd1);
    do_start(16'd1);
    check_val("t5_err_clr", 32'(err_len), 32'd0);
    base = beats;
    wait_beats(base + 1024, 3000, 1'b0, "t5_b_beats");
    send_result(1024);
    check_val("t5_err_ok", 32'(err_len), 32'd0);

    // 6: async reset mid frame, then a fresh run re-does config
    fft_cfg_tready  = 1'b0;
    ifft_cfg_tready = 1'b0;
    do_start(16'd2);
    check_val("t6_fft_vld", 32'(fft_cfg_tvalid), 32'd1);
    fft_cfg_tready  = 1'b1;
    ifft_cfg_tready = 1'b1;
    base = beats;
    wait_beats(base + 300, 3000, 1'b0, "t6_beat300");
    aresetn = 1'b0;
    #1;
    check_val("t6_rst_busy",  32'(busy), 32'd0);
    check_val("t6_rst_m_vld", 32'(m_sig_tvalid), 32'd0);
    check_val("t6_rst_sig_r", 32'(s_sig_tready), 32'd0);
    check_val("t6_rst_sf_r",  32'(s_sf_tready), 32'd0);
    check_val("t6_rst_tlast", 32'(m_sig_tlast), 32'd0);
    check_val("t6_rst_fft",   32'(fft_cfg_tvalid), 32'd0);
    check_val("t6_rst_cnt",   32'(frame_cnt), 32'd0);
    fft_cfg_tready  = 1'b0;
    ifft_cfg_tready = 1'b0;
    repeat (2) step();
    aresetn = 1'b1;
    step();
    do_start(16'd1);
    check_val("t6_recfg_fft", 32'(fft_cfg_tvalid), 32'd1);
    fft_cfg_tready = 1'b1;
    step();
    check_val("t6_recfg_ifft", 32'(ifft_cfg_tvalid), 32'd1);
    check_val("t6_cfg_no_strm", 32'(m_sig_tvalid), 32'd0);
    ifft_cfg_tready = 1'b1;
    base = beats;
    tl = tlast_cnt;
    wait_beats(base + 1024, 3000, 1'b0, "t6_beats");
    check_val("t6_tlast_cnt", tlast_cnt - tl, 32'd1);
    send_result(1024);
    check_val("t6_frame_cnt", 32'(frame_cnt), 32'd1);
    check_val("t6_err_len",   32'(err_len), 32'd0);

    // whole-run monitor totals
    check_val("all_viol",      viol, 32'd0);
    check_val("all_skew",      skew, 32'd0);
    check_val("all_order",     ord_err, 32'd0);
    check_val("all_tlast_pos", tlast_err, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
